// File: rtl/small_calculator_pkg.sv
// Shared types and widths for the small_calculator command driver.
package small_calculator_pkg;

    localparam int OP_W   = 2;
    localparam int DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] in1;
        logic [DATA_W-1:0] in2;
    } cmd_t;

endpackage

// File: rtl/small_calculator_driver_if.sv
// Command, calculator and response signal bundle for small_calculator_driver.
interface small_calculator_driver_if;
    import small_calculator_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [DATA_W-1:0] cmd_in1;
    logic [DATA_W-1:0] cmd_in2;
    logic              calc_go;
    logic [OP_W-1:0]   calc_op;
    logic [DATA_W-1:0] calc_in1;
    logic [DATA_W-1:0] calc_in2;
    logic              calc_done;
    logic [DATA_W-1:0] calc_out;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              busy;

    // slave: the driver itself; master: the surrounding environment
    modport slave (
        input  cmd_valid, cmd_op, cmd_in1, cmd_in2, calc_done, calc_out, rsp_ready,
        output cmd_ready, calc_go, calc_op, calc_in1, calc_in2, rsp_valid, rsp_data,
               rsp_err, busy
    );

    modport master (
        output cmd_valid, cmd_op, cmd_in1, cmd_in2, calc_done, calc_out, rsp_ready,
        input  cmd_ready, calc_go, calc_op, calc_in1, calc_in2, rsp_valid, rsp_data,
               rsp_err, busy
    );

endinterface

// File: rtl/small_calculator_cmd_fifo.sv
// Command FIFO; pointers carry one extra wrap bit to tell full from empty.
module small_calculator_cmd_fifo
    import small_calculator_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  cmd_t wdata,
    output cmd_t rdata,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    cmd_t        mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // storage carries no reset: only the pointers decide what is valid
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/small_calculator_driver.sv
// Queues calculator commands, issues them one at a time and returns each
// result (or a timeout error) on a valid/ready response port.
module small_calculator_driver
    import small_calculator_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    small_calculator_driver_if.slave bus
);

    localparam int                CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    cmd_t             head;
    cmd_t             issue_cmd;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] wait_cnt;
    logic [DATA_W-1:0] rsp_data_r;
    logic             rsp_err_r;

    assign push = bus.cmd_valid && !full;
    assign pop  = (state == IDLE) && !empty;

    small_calculator_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata ('{op: bus.cmd_op, in1: bus.cmd_in1, in2: bus.cmd_in2}),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (!empty) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (bus.calc_done || (wait_cnt == CNT_LAST)) state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // done is tested before the timeout so a late done still counts as success
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cmd  <= '0;
            wait_cnt   <= '0;
            rsp_data_r <= '0;
            rsp_err_r  <= 1'b0;
        end else begin
            if (pop) issue_cmd <= head;
            case (state)
                ISSUE: wait_cnt <= '0;
                WAIT: begin
                    if (bus.calc_done) begin
                        rsp_data_r <= bus.calc_out;
                        rsp_err_r  <= 1'b0;
                    end else if (wait_cnt == CNT_LAST) begin
                        rsp_data_r <= '0;
                        rsp_err_r  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready = !full;
    assign bus.calc_go   = (state == ISSUE);
    assign bus.calc_op   = issue_cmd.op;
    assign bus.calc_in1  = issue_cmd.in1;
    assign bus.calc_in2  = issue_cmd.in2;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.busy      = (state != IDLE) || !empty;

endmodule

// File: tb/tb_small_calculator_driver.sv
// Directed bench for small_calculator_driver; the bench plays the calculator stub.
module tb_small_calculator_driver;

    logic clk;
    logic rst_n;
    int   tests;
    int   failed;

    small_calculator_driver_if bus ();

    small_calculator_driver #(
        .DEPTH   (4),
        .TIMEOUT (15)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_in1   = a;
        bus.cmd_in2   = b;
        step();
        bus.cmd_valid = 1'b0;
    endtask

    // waits (bounded) for the go pulse and checks the issued operands
    task automatic expect_issue(input string tag, input logic [1:0] op,
                                input logic [3:0] a, input logic [3:0] b);
        int n = 0;
        while (!bus.calc_go && n < 6) begin
            step();
            n++;
        end
        chk({tag, "_go"},  bus.calc_go, 1);
        chk({tag, "_op"},  bus.calc_op, op);
        chk({tag, "_in1"}, bus.calc_in1, a);
        chk({tag, "_in2"}, bus.calc_in2, b);
    endtask

    // called in the go cycle: done arrives d cycles after go
    task automatic respond(input string tag, input int d, input logic [3:0] v);
        repeat (d) step();
        bus.calc_done = 1'b1;
        bus.calc_out  = v;
        step();
        bus.calc_done = 1'b0;
        bus.calc_out  = 4'h0;
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 1);
        chk({tag, "_rsp_data"},  bus.rsp_data, v);
        chk({tag, "_rsp_err"},   bus.rsp_err, 0);
    endtask

    task automatic consume(input string tag);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        chk({tag, "_rsp_drop"}, bus.rsp_valid, 0);
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        rst_n  = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_in1   = 4'd0;
        bus.cmd_in2   = 4'd0;
        bus.calc_done = 1'b0;
        bus.calc_out  = 4'd0;
        bus.rsp_ready = 1'b0;
        #2 rst_n = 1'b0;
        step();
        step();

        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_calc_go",   bus.calc_go, 0);
        chk("rst_calc_op",   bus.calc_op, 0);
        chk("rst_calc_in1",  bus.calc_in1, 0);
        chk("rst_calc_in2",  bus.calc_in2, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data",  bus.rsp_data, 0);
        chk("rst_rsp_err",   bus.rsp_err, 0);
        chk("rst_busy",      bus.busy, 0);
        rst_n = 1'b1;
        step();

        // 1: single command, done 6 cycles after go, 3+5=8
        push(2'd0, 4'd3, 4'd5);
        chk("t1_no_go_yet", bus.calc_go, 0);
        chk("t1_busy", bus.busy, 1);
        step();
        chk("t1_go", bus.calc_go, 1);
        chk("t1_in1", bus.calc_in1, 3);
        chk("t1_in2", bus.calc_in2, 5);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("t1_go_low", bus.calc_go, 0);
            chk("t1_wait_in1", bus.calc_in1, 3);
            chk("t1_wait_in2", bus.calc_in2, 5);
            chk("t1_wait_novalid", bus.rsp_valid, 0);
        end
        respond("t1", 1, 4'd8);
        consume("t1");
        chk("t1_idle_busy", bus.busy, 0);

        // 2: six back-to-back pushes with the stub stalled: five accepted
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.cmd_op  = i[1:0];
            bus.cmd_in1 = 4'(i + 1);
            bus.cmd_in2 = 4'(i + 8);
            chk("t2_cmd_ready", bus.cmd_ready, (i < 5) ? 1 : 0);
            step();
        end
        bus.cmd_valid = 1'b0;
        chk("t2_inflight_in1", bus.calc_in1, 1);
        chk("t2_full", bus.cmd_ready, 0);
        respond("t2_c0", 0, 4'hA);
        consume("t2_c0");
        chk("t2_still_full", bus.cmd_ready, 0);
        for (int i = 1; i < 5; i++) begin
            expect_issue("t2_issue", i[1:0], 4'(i + 1), 4'(i + 8));
            chk("t2_ready_back", bus.cmd_ready, 1);
            respond("t2_cn", 1, 4'(i));
            consume("t2_cn");
        end
        step();
        chk("t2_sixth_dropped_go", bus.calc_go, 0);
        chk("t2_sixth_dropped_busy", bus.busy, 0);

        // 3: timeout with a second command queued behind it
        push(2'd1, 4'd9, 4'd2);
        push(2'd2, 4'd4, 4'd4);
        expect_issue("t3_a", 2'd1, 4'd9, 4'd2);
        for (int i = 1; i <= 15; i++) begin
            step();
            chk("t3_no_rsp_yet", bus.rsp_valid, 0);
        end
        step();
        chk("t3_to_valid", bus.rsp_valid, 1);
        chk("t3_to_err", bus.rsp_err, 1);
        chk("t3_to_data", bus.rsp_data, 0);
        consume("t3_a");
        expect_issue("t3_b", 2'd2, 4'd4, 4'd4);
        respond("t3_b", 2, 4'h8);
        consume("t3_b");

        // 4: response held for 10 cycles with a command queued behind it
        push(2'd0, 4'd1, 4'd1);
        expect_issue("t4_c", 2'd0, 4'd1, 4'd1);
        push(2'd1, 4'd6, 4'd2);
        bus.calc_done = 1'b1;
        bus.calc_out  = 4'd5;
        step();
        bus.calc_done = 1'b0;
        bus.calc_out  = 4'd0;
        for (int i = 0; i < 10; i++) begin
            chk("t4_hold_valid", bus.rsp_valid, 1);
            chk("t4_hold_data", bus.rsp_data, 5);
            chk("t4_hold_nogo", bus.calc_go, 0);
            chk("t4_hold_busy", bus.busy, 1);
            step();
        end
        consume("t4_c");
        expect_issue("t4_d", 2'd1, 4'd6, 4'd2);
        respond("t4_d", 1, 4'd3);

        // 5: reset during WAIT with two commands queued (pending response in RESP first)
        consume("t4_d");
        push(2'd2, 4'd2, 4'd3);
        expect_issue("t5_e", 2'd2, 4'd2, 4'd3);
        push(2'd1, 4'd5, 4'd5);
        push(2'd3, 4'd6, 4'd6);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_go", bus.calc_go, 0);
        chk("t5_rst_op", bus.calc_op, 0);
        chk("t5_rst_in1", bus.calc_in1, 0);
        chk("t5_rst_in2", bus.calc_in2, 0);
        chk("t5_rst_valid", bus.rsp_valid, 0);
        chk("t5_rst_data", bus.rsp_data, 0);
        chk("t5_rst_ready", bus.cmd_ready, 1);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_after_busy", bus.busy, 0);
            chk("t5_after_go", bus.calc_go, 0);
            chk("t5_after_valid", bus.rsp_valid, 0);
        end
        push(2'd3, 4'd7, 4'd1);
        expect_issue("t5_new", 2'd3, 4'd7, 4'd1);
        respond("t5_new", 3, 4'd8);
        consume("t5_new");

        // 6: stray done while IDLE and during ISSUE must be ignored
        bus.calc_done = 1'b1;
        bus.calc_out  = 4'hF;
        step();
        bus.calc_done = 1'b0;
        chk("t6_idle_valid", bus.rsp_valid, 0);
        chk("t6_idle_busy", bus.busy, 0);
        push(2'd0, 4'd2, 4'd2);
        expect_issue("t6_h", 2'd0, 4'd2, 4'd2);
        bus.calc_done = 1'b1;
        bus.calc_out  = 4'hF;
        step();
        bus.calc_done = 1'b0;
        bus.calc_out  = 4'd0;
        chk("t6_issue_done_ignored", bus.rsp_valid, 0);
        respond("t6_h", 1, 4'd4);
        consume("t6_h");
        chk("t6_final_busy", bus.busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/small_calculator_driver.md
Name: small_calculator_driver

Overview:
Upstream command stage for small_calculator. It accepts operation commands over a valid/ready interface, buffers them in a small FIFO, and issues each one to the calculator as a one-cycle go pulse with stable operands. It waits for done, captures out, and presents each result, or a timeout error, on a valid/ready response port. Commands are issued one at a time, in order.

Parameters:
DEPTH, 4, command FIFO entries (power of two, >=2)
TIMEOUT, 15, maximum WAIT cycles for calc_done before an error response (>=2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept a command
cmd_op  input  2  operation code, passed through unchanged
cmd_in1  input  4  operand 1
cmd_in2  input  4  operand 2
calc_go  output  1  go pulse to calculator
calc_op  output  2  op to calculator
calc_in1  output  4  in1 to calculator
calc_in2  output  4  in2 to calculator
calc_done  input  1  calculator done
calc_out  input  4  calculator result, valid while calc_done=1
rsp_valid  output  1  result available
rsp_ready  input  1  consumer accepts result
rsp_data  output  4  captured result
rsp_err  output  1  1 = timeout, rsp_data=0
busy  output  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset (rst_n=0, async): state=IDLE, FIFO emptied. calc_go, calc_op, calc_in1, calc_in2, rsp_valid, rsp_data, rsp_err and the wait counter are 0. cmd_ready=1 once the FIFO is empty.
- Reset mid-operation: the in-flight command, any pending result and all queued commands are discarded. No response is produced for them.
- FIFO:
  - Push when cmd_valid && cmd_ready. cmd_ready = !full, with no pass-through when full.
  - Push and pop in the same cycle are both performed.
  - Pointers wrap modulo DEPTH. Ordering is strictly FIFO.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if FIFO is non-empty, at the clock edge load calc_op/in1/in2 from the head, pop, and go to ISSUE. Otherwise stay.
  - ISSUE: calc_go=1 for exactly this cycle. Clear the wait counter. Go to WAIT.
  - WAIT:
    - If calc_done=1: rsp_data<=calc_out, rsp_err<=0, go to RESP.
    - Else if counter==TIMEOUT-1: rsp_data<=0, rsp_err<=1, go to RESP.
    - Else counter+1.
  - RESP: rsp_valid=1, with rsp_data and rsp_err held stable. When rsp_ready=1, go to IDLE at the edge.
- calc_op/in1/in2 are registered and change only on the IDLE->ISSUE load. They stay stable through ISSUE, WAIT and RESP.
- Latency:
  - A command pushed into an empty FIFO while in IDLE produces calc_go 2 cycles after the push edge.
  - rsp_valid rises 1 cycle after the calc_done cycle.
  - On timeout, rsp_valid rises TIMEOUT+1 cycles after the go cycle.
- Minimum command-to-command spacing: RESP->IDLE->ISSUE. The next go comes at least 2 cycles after the response handshake.
- calc_done outside WAIT, including in the ISSUE cycle, is ignored.
- done arriving in the same cycle the counter reaches TIMEOUT-1 counts as success (done has priority).
- rsp_valid deassertion after the handshake is registered, so rsp_valid=0 in the IDLE cycle that follows.

Decomposition:
- Package small_calculator_pkg:
  - state enum (IDLE/ISSUE/WAIT/RESP)
  - OP_W=2 and DATA_W=4 constants
  - command struct {op,in1,in2}
- Sub-module small_calculator_cmd_fifo: parameterised DEPTH, with async active-low reset, push/pop, full/empty.
- FSM, operand registers and timeout counter live in the top module.

Test Plan (bench drives calc_done/calc_out from a stub responder):
1. Push op=00,in1=3,in2=5; stub asserts done 6 cycles after go with out=8. Required: one-cycle calc_go 2 cycles after push, calc_in1=3/calc_in2=5 stable through WAIT, rsp_data=8 and rsp_err=0 one cycle after done.
2. DEPTH=4, stub stalled, push 6 back-to-back. Required: 5 accepted (1 in flight + 4 queued), cmd_ready=0 on the 6th. After each response is consumed, commands issue in push order and cmd_ready returns to 1.
3. Stub never asserts done, TIMEOUT=15. Required: rsp_valid with rsp_err=1 and rsp_data=0 exactly 16 cycles after the go cycle. The next queued command then issues normally.
4. Response ready but rsp_ready held 0 for 10 cycles. Required: rsp_valid=1 and rsp_data stable for all 10 cycles, no calc_go, queued commands stay queued.
5. Assert rst_n=0 during WAIT with 2 commands queued. Required: all outputs 0 immediately, busy=0 after release, no stale response. A new command (in1=7,in2=1) completes normally.
6. Stub pulses calc_done with out=F while IDLE and during the ISSUE cycle. Required: no rsp_valid, and the real done later in WAIT is captured correctly.
